controle_polinomio: RTL and testbench

//  Control block (BC) for the polynomial datapath (BO, module operativo).
//  - On a start request, sequences the BO control word (lx, m0, m1, m2, h, ls, lh, done) to evaluate
//    S = A*X^2 + B*X + C (Horner form) or S = A*X + B.
//  - Sits between the top-level handshake and the datapath; computes no data itself.

---
 rtl/controle_polinomio_pkg.sv | 46 ++++
 rtl/controle_polinomio.sv | 132 +++++++++++++
 tb/tb_controle_polinomio.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/controle_polinomio_pkg.sv
// Shared encodings between the polynomial control block and its datapath.
package controle_polinomio_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    OP1    = 3'd2,
    OP2    = 3'd3,
    OP3    = 3'd4,
    OP4    = 3'd5,
    DONE   = 3'd6
  } state_t;

  // operand1 (m1) sources
  localparam logic [1:0] SEL_CONST = 2'b00;
  localparam logic [1:0] SEL_X     = 2'b01;
  localparam logic [1:0] SEL_S     = 2'b10;
  localparam logic [1:0] SEL_H     = 2'b11;

  // operand2 (m2) sources use a different ordering than operand1
  localparam logic [1:0] OPND2_X     = 2'b00;
  localparam logic [1:0] OPND2_CONST = 2'b01;
  localparam logic [1:0] OPND2_S     = 2'b10;
  localparam logic [1:0] OPND2_H     = 2'b11;

  localparam logic [1:0] K_ZERO = 2'b00;
  localparam logic [1:0] K_A    = 2'b01;
  localparam logic [1:0] K_B    = 2'b10;
  localparam logic [1:0] K_C    = 2'b11;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_MUL = 1'b1;

  typedef struct packed {
    logic       busy;
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/controle_polinomio.sv
// Control block sequencing the datapath control word for Horner evaluation
// of A*X^2+B*X+C (mode 0) or A*X+B (mode 1).
module controle_polinomio
  import controle_polinomio_pkg::*;
#(
  parameter int unsigned OP_LAT = 1
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       lx,
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       h,
  output logic       ls,
  output logic       lh,
  output logic       done
);

  localparam int unsigned    CNT_W    = $clog2(OP_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             op_c, last_c, strobe_c;

  // State, wait counter, captured mode and registered control word
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next state, then the control word for that next state so outputs stay Moore and registered
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    mode_d   = mode_q;
    ctrl_d   = '0;
    op_c     = (state_q == OP1) || (state_q == OP2) || (state_q == OP3) || (state_q == OP4);
    last_c   = (cnt_q == CNT_LAST);
    strobe_c = 1'b0;

    if (op_c && !last_c) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_X;
          mode_d  = mode;
        end
      end
      LOAD_X: state_d = OP1;
      OP1:    if (last_c) state_d = mode_q ? OP4 : OP2;
      OP2:    if (last_c) state_d = OP3;
      OP3:    if (last_c) state_d = OP4;
      OP4:    if (last_c) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    strobe_c = (cnt_d == CNT_LAST);

    case (state_d)
      LOAD_X: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.lx   = 1'b1;
      end
      OP1: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.m1   = SEL_CONST;
        ctrl_d.m0   = K_A;
        ctrl_d.m2   = OPND2_X;
        ctrl_d.h    = ALU_MUL;
        ctrl_d.lh   = strobe_c;
      end
      OP2: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.m1   = SEL_H;
        ctrl_d.m2   = OPND2_CONST;
        ctrl_d.m0   = K_B;
        ctrl_d.h    = ALU_ADD;
        ctrl_d.lh   = strobe_c;
      end
      OP3: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.m1   = SEL_H;
        ctrl_d.m2   = OPND2_X;
        ctrl_d.m0   = K_ZERO;
        ctrl_d.h    = ALU_MUL;
        ctrl_d.lh   = strobe_c;
      end
      OP4: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.m1   = SEL_H;
        ctrl_d.m2   = OPND2_CONST;
        ctrl_d.m0   = mode_d ? K_B : K_C;
        ctrl_d.h    = ALU_ADD;
        ctrl_d.ls   = strobe_c;
      end
      DONE: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.done = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  assign busy = ctrl_q.busy;
  assign lx   = ctrl_q.lx;
  assign m0   = ctrl_q.m0;
  assign m1   = ctrl_q.m1;
  assign m2   = ctrl_q.m2;
  assign h    = ctrl_q.h;
  assign ls   = ctrl_q.ls;
  assign lh   = ctrl_q.lh;
  assign done = ctrl_q.done;

endmodule

// File: tb/tb_controle_polinomio.sv
// Bench for controle_polinomio: two instances (OP_LAT 1 and 3) driven in lockstep,
// each coupled to a behavioural datapath and checked against a run-schedule model.
module tb_controle_polinomio;
  import controle_polinomio_pkg::*;

  typedef ctrl_t cq_t[$];
  typedef struct {
    logic  s;
    logic  m;
    ctrl_t e;
  } vec_t;

  localparam logic [15:0] XV = 16'd2;
  localparam logic [15:0] AV = 16'd3;
  localparam logic [15:0] BV = 16'd4;
  localparam logic [15:0] CV = 16'd5;

  logic ck, rst, start, mode;
  logic busy1, lx1, h1, ls1, lh1, done1;
  logic busy3, lx3, h3, ls3, lh3, done3;
  logic [1:0] m0_1, m1_1, m2_1, m0_3, m1_3, m2_3;
  ctrl_t c1, c3;

  int checks, failures, cyc, done1_n, done3_n, done3_cyc;
  int done1_cycs[$];
  cq_t q1, q3;
  logic mrun1, mrun3;
  logic [15:0] x1, s1, hr1, x3, s3, hr3;
  vec_t tab[13];

  controle_polinomio #(.OP_LAT(1)) dut1 (
    .ck(ck), .rst(rst), .start(start), .mode(mode), .busy(busy1), .lx(lx1),
    .m0(m0_1), .m1(m1_1), .m2(m2_1), .h(h1), .ls(ls1), .lh(lh1), .done(done1));

  controle_polinomio #(.OP_LAT(3)) dut3 (
    .ck(ck), .rst(rst), .start(start), .mode(mode), .busy(busy3), .lx(lx3),
    .m0(m0_3), .m1(m1_3), .m2(m2_3), .h(h3), .ls(ls3), .lh(lh3), .done(done3));

  assign c1 = {busy1, lx1, m0_1, m1_1, m2_1, h1, ls1, lh1, done1};
  assign c3 = {busy3, lx3, m0_3, m1_3, m2_3, h3, ls3, lh3, done3};

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Behavioural datapath
  function automatic logic [15:0] alu(input ctrl_t c, input logic [15:0] x, s, hr);
    logic [15:0] k, a, b;
    case (c.m0)
      K_ZERO:  k = 16'd0;
      K_A:     k = AV;
      K_B:     k = BV;
      K_C:     k = CV;
      default: k = 16'd0;
    endcase
    case (c.m1)
      SEL_CONST: a = k;
      SEL_X:     a = x;
      SEL_S:     a = s;
      SEL_H:     a = hr;
      default:   a = 16'd0;
    endcase
    case (c.m2)
      OPND2_X:     b = x;
      OPND2_CONST: b = k;
      OPND2_S:     b = s;
      OPND2_H:     b = hr;
      default:     b = 16'd0;
    endcase
    return (c.h == ALU_MUL) ? 16'(a * b) : ((c.h == ALU_ADD) ? 16'(a + b) : 16'd0);
  endfunction

  always @(posedge ck) begin
    if (c1.lx) x1 <= XV;
    if (c1.ls) s1 <= alu(c1, x1, s1, hr1);
    if (c1.lh) hr1 <= alu(c1, x1, s1, hr1);
    if (c3.lx) x3 <= XV;
    if (c3.ls) s3 <= alu(c3, x3, s3, hr3);
    if (c3.lh) hr3 <= alu(c3, x3, s3, hr3);
  end

  function automatic ctrl_t cw(input logic b, lxv, input logic [1:0] k, a, o,
                               input logic hv, lsv, lhv, dn);
    return {b, lxv, k, a, o, hv, lsv, lhv, dn};
  endfunction

  // Expected control words of a whole run, one per cycle after the accepting edge
  function automatic cq_t schedule(input int lat, input logic m);
    cq_t r;
    ctrl_t w;
    r.push_back(cw(1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      if (m && (k == 1 || k == 2)) continue;
      for (int i = 0; i < lat; i++) begin
        case (k)
          0:       w = cw(1, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
          1:       w = cw(1, 0, 2'b10, 2'b11, 2'b01, 0, 0, 0, 0);
          2:       w = cw(1, 0, 2'b00, 2'b11, 2'b00, 1, 0, 0, 0);
          default: w = cw(1, 0, m ? 2'b10 : 2'b11, 2'b11, 2'b01, 0, 0, 0, 0);
        endcase
        if (i == lat - 1) begin
          if (k == 3) w.ls = 1'b1;
          else        w.lh = 1'b1;
        end
        r.push_back(w);
      end
    end
    r.push_back(cw(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
    return r;
  endfunction

  task automatic check(input string nm, input logic [15:0] got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Compare this cycle against the model, then apply the inputs for this cycle
  task automatic step(input logic r, s, m, input logic use_tab, input ctrl_t tv);
    ctrl_t e1, e3;
    logic idle1, idle3;
    @(negedge ck);
    idle1 = (q1.size() == 0);
    idle3 = (q3.size() == 0);
    e1 = '0;
    e3 = '0;
    if (!idle1) e1 = q1.pop_front();
    if (!idle3) e3 = q3.pop_front();
    check("ctrl1", 16'(c1), 16'(e1));
    check("ctrl3", 16'(c3), 16'(e3));
    if (use_tab) check("table1", 16'(c1), 16'(tv));
    if (c1.done) begin
      done1_n++;
      done1_cycs.push_back(cyc);
      check("res1", s1, mrun1 ? 16'(AV * XV + BV) : 16'(AV * XV * XV + BV * XV + CV));
    end
    if (c3.done) begin
      done3_n++;
      done3_cyc = cyc;
      check("res3", s3, mrun3 ? 16'(AV * XV + BV) : 16'(AV * XV * XV + BV * XV + CV));
    end
    if (r) begin
      q1.delete();
      q3.delete();
    end else begin
      if (idle1 && s) begin q1 = schedule(1, m); mrun1 = m; end
      if (idle3 && s) begin q3 = schedule(3, m); mrun3 = m; end
    end
    rst = r; start = s; mode = m;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  initial begin
    int base, d0;
    checks = 0; failures = 0; cyc = 0; done1_n = 0; done3_n = 0; done3_cyc = -1;
    mrun1 = 0; mrun3 = 0;
    rst = 1; start = 0; mode = 0;
    repeat (2) @(posedge ck);
    step(1, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    tab[0]  = '{1, 0, cw(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)};
    tab[1]  = '{0, 1, cw(1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)};
    tab[2]  = '{0, 1, cw(1, 0, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0)};
    tab[3]  = '{0, 0, cw(1, 0, 2'b10, 2'b11, 2'b01, 0, 0, 1, 0)};
    tab[4]  = '{0, 0, cw(1, 0, 2'b00, 2'b11, 2'b00, 1, 0, 1, 0)};
    tab[5]  = '{0, 0, cw(1, 0, 2'b11, 2'b11, 2'b01, 0, 1, 0, 0)};
    tab[6]  = '{0, 0, cw(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1)};
    tab[7]  = '{1, 1, cw(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)};
    tab[8]  = '{0, 0, cw(1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)};
    tab[9]  = '{0, 0, cw(1, 0, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0)};
    tab[10] = '{0, 0, cw(1, 0, 2'b10, 2'b11, 2'b01, 0, 1, 0, 0)};
    tab[11] = '{0, 0, cw(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1)};
    tab[12] = '{0, 0, cw(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0)};

    // Mode 0 then mode 1 with OP_LAT=1; OP_LAT=3 instance runs mode 0 from the same start
    cyc = 0;
    done1_n = 0;
    for (int i = 0; i < 13; i++) step(0, tab[i].s, tab[i].m, 1, tab[i].e);
    idle(4);
    check("done3_cycle", 16'(done3_cyc), 16'd14);
    check("done1_count", 16'(done1_n), 16'd2);
    idle(10);

    // start pulses while busy are ignored
    base = cyc; d0 = done1_n;
    step(0, 1, 0, 0, '0); step(0, 0, 0, 0, '0);
    step(0, 1, 1, 0, '0); step(0, 0, 0, 0, '0);
    step(0, 1, 1, 0, '0);
    idle(4);
    check("ignored_starts", 16'(done1_n - d0), 16'd1);
    check("busy_done_cycle", 16'(done1_cycs[done1_cycs.size()-1] - base), 16'd6);
    idle(16);

    // rst mid-sequence, then a clean run
    base = cyc; d0 = done1_n;
    step(0, 1, 0, 0, '0); step(0, 0, 0, 0, '0); step(0, 0, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0); step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    idle(8);
    check("rst_one_done", 16'(done1_n - d0), 16'd1);
    check("rst_done_cycle", 16'(done1_cycs[done1_cycs.size()-1] - base), 16'd12);
    idle(16);

    // start held high: back-to-back runs
    base = cyc; d0 = done1_cycs.size();
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, '0);
    idle(10);
    check("held_runs", 16'(done1_cycs.size() - d0), 16'd3);
    check("held_first", 16'(done1_cycs[d0] - base), 16'd6);
    check("held_gap", 16'(done1_cycs[d0+1] - done1_cycs[d0]), 16'd7);
    idle(16);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), 0, '0);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
